// File: rtl/sd_scheduler.sv
// Round-robin arbiter sharing the single sd_card sector channel between four requesters.
// A request is latched, issued as a one-hot start, and completed on rdone or timeout.
module sd_scheduler #(
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [3:0]   req_rd,
  input  logic [3:0]   req_wr,
  input  logic [127:0] req_sector,
  input  logic [31:0]  req_inbyte,
  output logic [3:0]   src_busy,
  output logic [3:0]   src_done,
  output logic [3:0]   src_err,
  output logic [3:0]   src_outen,
  output logic [3:0]   sd_rstart,
  output logic [3:0]   sd_wstart,
  output logic [31:0]  sd_rsector,
  output logic [7:0]   sd_inbyte,
  input  logic         sd_rdone,
  input  logic         sd_outen
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_COMPLETE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_pend_rd;
  logic [3:0]  r_pend_wr;
  logic [31:0] r_sec [4];
  logic [1:0]  r_gnt;
  logic [1:0]  r_last;
  logic        r_dir_rd;
  logic        r_err;
  logic [23:0] r_cnt;
  logic [31:0] r_rsector;

  logic [3:0]  w_pend;
  logic [3:0]  w_busy;
  logic [3:0]  w_gnt_oh;
  logic [1:0]  w_pick;
  logic        w_any;
  logic        w_grant;
  logic [23:0] w_cnt_inc;
  logic        w_timeout;

  assign w_pend    = r_pend_rd | r_pend_wr;
  assign w_gnt_oh  = 4'b0001 << r_gnt;
  assign w_grant   = (r_state == ST_IDLE) && w_any;
  assign w_cnt_inc = (r_cnt == 24'hFF_FFFF) ? r_cnt : r_cnt + 24'd1;
  assign w_timeout = (TIMEOUT != 24'd0) && (w_cnt_inc == TIMEOUT);

  // Descending scan so the nearest pending index after r_last wins.
  always_comb begin
    logic [1:0] idx;
    w_pick = 2'd0;
    w_any  = 1'b0;
    idx    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = r_last + 2'(k);
      if (w_pend[idx]) begin
        w_pick = idx;
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_busy[i] = w_pend[i] | ((r_state != ST_IDLE) && (r_gnt == 2'(i)));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE:    if (sd_rdone || w_timeout) w_state_nxt = ST_COMPLETE;
      ST_COMPLETE: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_rd <= 4'd0;
      r_pend_wr <= 4'd0;
      r_gnt     <= 2'd0;
      r_last    <= 2'd3;
      r_dir_rd  <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= 24'd0;
      r_rsector <= 32'd0;
    end else begin
      if (w_grant) begin
        r_gnt     <= w_pick;
        r_last    <= w_pick;
        r_dir_rd  <= r_pend_rd[w_pick];
        r_rsector <= r_sec[w_pick];
        r_cnt     <= 24'd0;
        r_err     <= 1'b0;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= w_cnt_inc;
        if (!sd_rdone && w_timeout) r_err <= 1'b1;
      end
      // A read wins over a simultaneous write from the same source.
      for (int i = 0; i < 4; i++) begin
        if (w_grant && (w_pick == 2'(i))) begin
          r_pend_rd[i] <= 1'b0;
          r_pend_wr[i] <= 1'b0;
        end else if (!w_busy[i] && (req_rd[i] || req_wr[i])) begin
          r_pend_rd[i] <= req_rd[i];
          r_pend_wr[i] <= ~req_rd[i] & req_wr[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!w_busy[i] && (req_rd[i] || req_wr[i])) r_sec[i] <= req_sector[32*i +: 32];
    end
  end

  // The one-cycle COMPLETE state keeps every start low so sd_card sees a fresh edge.
  always_comb begin
    src_busy  = w_busy;
    sd_rstart = 4'd0;
    sd_wstart = 4'd0;
    src_done  = 4'd0;
    src_err   = 4'd0;
    src_outen = 4'd0;
    sd_inbyte = 8'h00;
    if (r_state == ST_ISSUE) begin
      if (r_dir_rd) sd_rstart = w_gnt_oh;
      else          sd_wstart = w_gnt_oh;
      if (sd_outen) src_outen = w_gnt_oh;
      sd_inbyte = req_inbyte[8*r_gnt +: 8];
    end
    if (r_state == ST_COMPLETE) begin
      src_done = w_gnt_oh;
      if (r_err) src_err = w_gnt_oh;
    end
  end

  assign sd_rsector = r_rsector;

endmodule

// File: tb/tb_sd_scheduler.sv
// Directed bench for sd_scheduler: one instance with timeout disabled, one with TIMEOUT=100.
module tb_sd_scheduler;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_rd;
  logic [3:0]   req_wr;
  logic [127:0] req_sector;
  logic [31:0]  req_inbyte;
  logic         sd_rdone;
  logic         sd_outen;

  logic [3:0]  src_busy, src_done, src_err, src_outen, sd_rstart, sd_wstart;
  logic [31:0] sd_rsector;
  logic [7:0]  sd_inbyte;

  logic [3:0]  t_src_busy, t_src_done, t_src_err, t_src_outen, t_sd_rstart, t_sd_wstart;
  logic [31:0] t_sd_rsector;
  logic [7:0]  t_sd_inbyte;

  int checks = 0;
  int errors = 0;

  sd_scheduler #(.TIMEOUT(24'd0)) dut (
    .clk(clk), .rstn(rstn), .req_rd(req_rd), .req_wr(req_wr),
    .req_sector(req_sector), .req_inbyte(req_inbyte),
    .src_busy(src_busy), .src_done(src_done), .src_err(src_err), .src_outen(src_outen),
    .sd_rstart(sd_rstart), .sd_wstart(sd_wstart), .sd_rsector(sd_rsector),
    .sd_inbyte(sd_inbyte), .sd_rdone(sd_rdone), .sd_outen(sd_outen)
  );

  sd_scheduler #(.TIMEOUT(24'd100)) dut_t (
    .clk(clk), .rstn(rstn), .req_rd(req_rd), .req_wr(req_wr),
    .req_sector(req_sector), .req_inbyte(req_inbyte),
    .src_busy(t_src_busy), .src_done(t_src_done), .src_err(t_src_err), .src_outen(t_src_outen),
    .sd_rstart(t_sd_rstart), .sd_wstart(t_sd_wstart), .sd_rsector(t_sd_rsector),
    .sd_inbyte(t_sd_inbyte), .sd_rdone(sd_rdone), .sd_outen(sd_outen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_ctl", {8'h0, src_busy, src_done, src_err, src_outen, sd_rstart, sd_wstart}, 32'h0);
    chk("rst_sector", sd_rsector, 32'h0);
    chk("rst_inbyte", {24'h0, sd_inbyte}, 32'h0);
    chk("rst_t_ctl", {8'h0, t_src_busy, t_src_done, t_src_err, t_src_outen, t_sd_rstart, t_sd_wstart}, 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_start(input string tag, output logic [3:0] rs, output logic [3:0] ws);
    int n = 0;
    while (sd_rstart == 4'd0 && sd_wstart == 4'd0 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, {31'h0, n < 50}, 32'h1);
    rs = sd_rstart;
    ws = sd_wstart;
  endtask

  task automatic finish_req(input string tag, input logic [3:0] exp_done);
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    chk({tag, "_done"}, {28'h0, src_done}, {28'h0, exp_done});
    chk({tag, "_err"}, {28'h0, src_err}, 32'h0);
    chk({tag, "_startlow"}, {24'h0, sd_rstart, sd_wstart}, 32'h0);
    chk({tag, "_inbyte0"}, {24'h0, sd_inbyte}, 32'h0);
    tick();
    chk({tag, "_donegone"}, {28'h0, src_done}, 32'h0);
    chk({tag, "_idlelow"}, {24'h0, sd_rstart, sd_wstart}, 32'h0);
  endtask

  initial begin
    logic [3:0] rs, ws;
    int n, extra, bad_outen;

    rstn = 1'b0;
    req_rd = 4'd0;
    req_wr = 4'd0;
    req_sector = 128'd0;
    req_inbyte = 32'd0;
    sd_rdone = 1'b0;
    sd_outen = 1'b0;
    tick();
    do_reset();

    // Single read from source 2
    req_sector[95:64] = 32'h0000_1234;
    req_rd = 4'b0100;
    tick();
    req_rd = 4'b0000;
    chk("rd_busy_c1", {28'h0, src_busy}, 32'h4);
    chk("rd_start_c1", {28'h0, sd_rstart}, 32'h0);
    tick();
    chk("rd_rstart_c2", {28'h0, sd_rstart}, 32'h4);
    chk("rd_wstart_c2", {28'h0, sd_wstart}, 32'h0);
    chk("rd_sector", sd_rsector, 32'h0000_1234);
    bad_outen = 0;
    for (int i = 0; i < 512; i++) begin
      sd_outen = 1'b1;
      #1;
      if (src_outen !== 4'b0100) bad_outen++;
      sd_outen = 1'b0;
      #1;
      if (src_outen !== 4'b0000) bad_outen++;
      tick();
    end
    chk("rd_outen_steer", bad_outen, 32'd0);
    chk("rd_rstart_held", {28'h0, sd_rstart}, 32'h4);
    chk("rd_sector_held", sd_rsector, 32'h0000_1234);
    finish_req("rd", 4'b0100);
    chk("rd_busy_after", {28'h0, src_busy}, 32'h0);

    // Round-robin 0,1,3 then re-request of 0 during service of 1
    do_reset();
    req_sector[31:0]   = 32'h10;
    req_sector[63:32]  = 32'h11;
    req_sector[127:96] = 32'h13;
    req_rd = 4'b1011;
    tick();
    req_rd = 4'b0000;
    wait_start("rr0", rs, ws);
    chk("rr0_start", {28'h0, rs}, 32'h1);
    chk("rr0_sector", sd_rsector, 32'h10);
    finish_req("rr0", 4'b0001);
    wait_start("rr1", rs, ws);
    chk("rr1_start", {28'h0, rs}, 32'h2);
    chk("rr1_sector", sd_rsector, 32'h11);
    req_sector[31:0] = 32'h20;
    req_rd = 4'b0001;
    tick();
    req_rd = 4'b0000;
    chk("rr1_busy", {28'h0, src_busy}, 32'hB);
    finish_req("rr1", 4'b0010);
    wait_start("rr3", rs, ws);
    chk("rr3_start", {28'h0, rs}, 32'h8);
    chk("rr3_sector", sd_rsector, 32'h13);
    finish_req("rr3", 4'b1000);
    wait_start("rr0b", rs, ws);
    chk("rr0b_start", {28'h0, rs}, 32'h1);
    chk("rr0b_sector", sd_rsector, 32'h20);
    finish_req("rr0b", 4'b0001);

    // Write from source 1
    req_sector[63:32] = 32'h55;
    req_inbyte[15:8] = 8'hA5;
    req_wr = 4'b0010;
    tick();
    req_wr = 4'b0000;
    tick();
    chk("wr_wstart", {28'h0, sd_wstart}, 32'h2);
    chk("wr_rstart", {28'h0, sd_rstart}, 32'h0);
    chk("wr_inbyte", {24'h0, sd_inbyte}, 32'hA5);
    chk("wr_sector", sd_rsector, 32'h55);
    finish_req("wr", 4'b0010);

    // Read+write collision and duplicate request on source 3
    req_rd = 4'b1000;
    req_wr = 4'b1000;
    tick();
    req_wr = 4'b0000;
    tick();
    req_rd = 4'b0000;
    wait_start("dup", rs, ws);
    chk("dup_rstart", {28'h0, rs}, 32'h8);
    chk("dup_wstart", {28'h0, ws}, 32'h0);
    req_rd = 4'b1000;
    tick();
    req_rd = 4'b0000;
    finish_req("dup", 4'b1000);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (src_done !== 4'd0 || sd_rstart !== 4'd0 || sd_wstart !== 4'd0) extra++;
      tick();
    end
    chk("dup_no_extra", extra, 32'd0);

    // Timeout on the TIMEOUT=100 instance, with source 1 queued behind source 0
    do_reset();
    req_rd = 4'b0011;
    tick();
    req_rd = 4'b0000;
    tick();
    chk("to_start", {28'h0, t_sd_rstart}, 32'h1);
    n = 0;
    while (t_sd_rstart == 4'b0001 && n < 200) begin
      n++;
      tick();
    end
    chk("to_high_cycles", n, 32'd100);
    chk("to_done", {28'h0, t_src_done}, 32'h1);
    chk("to_err", {28'h0, t_src_err}, 32'h1);
    tick();
    tick();
    chk("to_next_start", {28'h0, t_sd_rstart}, 32'h2);
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    chk("to_next_done", {28'h0, t_src_done}, 32'h2);
    chk("to_next_err", {28'h0, t_src_err}, 32'h0);

    // Asynchronous reset in the middle of ISSUE
    do_reset();
    req_rd = 4'b0001;
    tick();
    req_rd = 4'b0000;
    tick();
    chk("mr_start", {28'h0, sd_rstart}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_ctl", {8'h0, src_busy, src_done, src_err, src_outen, sd_rstart, sd_wstart}, 32'h0);
    chk("mr_sector", sd_rsector, 32'h0);
    chk("mr_inbyte", {24'h0, sd_inbyte}, 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    sd_rdone = 1'b1;
    tick();
    sd_rdone = 1'b0;
    chk("mr_stray_done", {28'h0, src_done}, 32'h0);
    tick();
    chk("mr_quiet", {20'h0, src_done, src_busy, sd_rstart}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
